// File: rtl/sdram_line_adapter_if.sv
// Line-side and core-side bundles for sdram_line_adapter.
// line: cache/DMA master -> adapter; core: adapter -> SDRAM core port.
interface sdram_line_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 25,
    parameter int LINE_WORDS = 4,
    parameter int WORD_LEN   = DATA_WIDTH / 8
);
    logic                             line_req;
    logic                             line_we;
    logic [ADDR_WIDTH-1:0]            line_addr;
    logic [LINE_WORDS*DATA_WIDTH-1:0] line_wdata;
    logic [LINE_WORDS*WORD_LEN-1:0]   line_wstrb;
    logic                             line_busy;
    logic                             line_done;
    logic [LINE_WORDS*DATA_WIDTH-1:0] line_rdata;

    modport master (
        output line_req,
        output line_we,
        output line_addr,
        output line_wdata,
        output line_wstrb,
        input  line_busy,
        input  line_done,
        input  line_rdata
    );

    modport slave (
        input  line_req,
        input  line_we,
        input  line_addr,
        input  line_wdata,
        input  line_wstrb,
        output line_busy,
        output line_done,
        output line_rdata
    );
endinterface

interface sdram_core_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 25,
    parameter int WORD_LEN   = DATA_WIDTH / 8
);
    logic                  core_rd;
    logic [WORD_LEN-1:0]   core_wr;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic                  core_rdy;
    logic                  core_rvalid;
    logic                  core_wvalid;
    logic [DATA_WIDTH-1:0] core_rdata;

    modport master (
        output core_rd,
        output core_wr,
        output core_addr,
        output core_wdata,
        input  core_rdy,
        input  core_rvalid,
        input  core_wvalid,
        input  core_rdata
    );

    modport slave (
        input  core_rd,
        input  core_wr,
        input  core_addr,
        input  core_wdata,
        output core_rdy,
        output core_rvalid,
        output core_wvalid,
        output core_rdata
    );
endinterface

// File: rtl/sdram_line_adapter.sv
// Splits one cache-line request into single-word SDRAM core accesses.
// Define SDRAM_LINE_CWF_EN for critical-word-first line reads.
module sdram_line_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 25,
    parameter int LINE_WORDS = 4,
    parameter int WORD_LEN   = DATA_WIDTH / 8
) (
    input  logic         clk,
    input  logic         rst,
    sdram_line_if.slave  lif,
    sdram_core_if.master cif
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int WL_W  = $clog2(WORD_LEN);
    localparam int OFF_W = $clog2(LINE_WORDS * WORD_LEN);
    localparam int LDW   = LINE_WORDS * DATA_WIDTH;
    localparam int LSW   = LINE_WORDS * WORD_LEN;

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
        ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LDW-1:0]        wdata_q;
    logic [LSW-1:0]        wstrb_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic [LDW-1:0]        rdata_q;
    logic                  rd_q;
    logic [WORD_LEN-1:0]   wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] cwdata_q;

    logic [ADDR_WIDTH-1:0] base_d;
    logic [IDX_W-1:0]      start_d;
    logic [IDX_W-1:0]      idx_d;
    logic [ADDR_WIDTH-1:0] waddr_d;
    logic [WORD_LEN-1:0]   strb_sel;
    logic [DATA_WIDTH-1:0] data_sel;
    logic                  last;
    logic                  word_done;

    assign base_d = lif.line_addr & ~OFF_MASK;

`ifdef SDRAM_LINE_CWF_EN
    // Reads begin at the requested word; writes always sweep from word 0.
    assign start_d = lif.line_we ? '0
                                 : lif.line_addr[OFF_W-1:WL_W];
`else
    assign start_d = '0;
`endif

    assign idx_d    = idx_q + 1'b1;
    assign waddr_d  = base_q + (ADDR_WIDTH'(idx_q) << WL_W);
    assign strb_sel = wstrb_q[int'(idx_q)*WORD_LEN +: WORD_LEN];
    assign data_sel = wdata_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign last     = (cnt_q == LAST);
    assign word_done = we_q ? cif.core_wvalid : cif.core_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            base_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= '0;
            addr_q   <= '0;
            cwdata_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (lif.line_req) begin
                        we_q    <= lif.line_we;
                        base_q  <= base_d;
                        wdata_q <= lif.line_wdata;
                        wstrb_q <= lif.line_wstrb;
                        idx_q   <= start_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (we_q && strb_sel == '0) begin
                        if (last) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q <= idx_d;
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        rd_q     <= ~we_q;
                        wr_q     <= we_q ? strb_sel : '0;
                        addr_q   <= waddr_d;
                        cwdata_q <= we_q ? data_sel : '0;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cif.core_rdy) begin
                        rd_q    <= 1'b0;
                        wr_q    <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (word_done) begin
                        if (!we_q) begin
                            rdata_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH]
                                <= cif.core_rdata;
                        end
                        if (last) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_d;
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= S_SEL;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign lif.line_busy  = busy_q;
    assign lif.line_done  = done_q;
    assign lif.line_rdata = rdata_q;

    assign cif.core_rd    = rd_q;
    assign cif.core_wr    = wr_q;
    assign cif.core_addr  = addr_q;
    assign cif.core_wdata = cwdata_q;
endmodule

// File: tb/tb_sdram_line_adapter.sv
// Self-checking bench for sdram_line_adapter: vector table,
// request scoreboard and a small SDRAM core model.
module tb_sdram_line_adapter;
    localparam int DW = 32;
    localparam int AW = 25;
    localparam int LW = 4;
    localparam int WL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_line_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WORDS(LW),
                    .WORD_LEN(WL)) lif ();
    sdram_core_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                    .WORD_LEN(WL)) cif ();

    sdram_line_adapter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LINE_WORDS(LW),
        .WORD_LEN(WL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lif(lif.slave),
        .cif(cif.master)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [127:0]  wdata;
        logic [15:0]   wstrb;
        int            stall;
        int            exp_reqs;
        int            exp_cyc;
        logic [127:0]  exp_rdata;
    } vec_t;

    typedef struct {
        logic          rd;
        logic [3:0]    wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] mem [logic [AW-1:0]];
    vec_t        vecs [8];

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int pops = 0;
    int cur_stall = 0;
    logic spur = 1'b0;

    function automatic void chk(input string nm,
                                input logic [127:0] act,
                                input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] rd_mem(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hD000_0000 | 32'(a);
    endfunction

    always @(negedge clk) begin
        if (lif.line_done === 1'b1) done_cnt++;
    end

    // Core model: programmable stall, fixed response latency.
    initial begin : core_model
        logic        act;
        logic        pend;
        logic        pend_rd;
        logic [AW-1:0] pend_addr;
        int          resp_wait;
        int          stall_left;
        logic        have_prev;
        logic        chk_clear;
        logic [61:0] prev;
        logic [61:0] cur;
        logic [31:0] old;
        req_t        e;
        pend = 1'b0;
        pend_rd = 1'b0;
        pend_addr = '0;
        resp_wait = 0;
        stall_left = 0;
        have_prev = 1'b0;
        chk_clear = 1'b0;
        prev = '0;
        cif.core_rdy = 1'b0;
        cif.core_rvalid = 1'b0;
        cif.core_wvalid = 1'b0;
        cif.core_rdata = '0;
        forever begin
            @(negedge clk);
            act = cif.core_rd || (cif.core_wr != 4'h0);
            cur = {cif.core_rd, cif.core_wr, cif.core_addr, cif.core_wdata};
            if (chk_clear) begin
                chk("req_clear", {cif.core_rd, cif.core_wr}, 0);
                chk_clear = 1'b0;
            end
            if (act) chk("one_outstanding", pend, 0);
            if (act && have_prev) chk("issue_stable", cur, prev);
            cif.core_rvalid = 1'b0;
            cif.core_wvalid = 1'b0;
            if (rst) begin
                pend = 1'b0;
                have_prev = 1'b0;
            end
            if (spur) begin
                cif.core_rvalid = 1'b1;
                cif.core_wvalid = 1'b1;
                cif.core_rdata = 32'hDEAD_BEEF;
            end else if (pend) begin
                if (resp_wait > 0) resp_wait--;
                else begin
                    if (pend_rd) begin
                        cif.core_rvalid = 1'b1;
                        cif.core_rdata = rd_mem(pend_addr);
                    end else begin
                        cif.core_wvalid = 1'b1;
                    end
                    pend = 1'b0;
                end
            end
            if (act && stall_left > 0) begin
                cif.core_rdy = 1'b0;
                stall_left--;
                have_prev = 1'b1;
                prev = cur;
            end else if (act) begin
                cif.core_rdy = 1'b1;
                pops++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_req: got addr %0h expected none",
                             cif.core_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_rd", cif.core_rd, e.rd);
                    chk("req_wr", cif.core_wr, e.wr);
                    chk("req_addr", cif.core_addr, e.addr);
                    if (!e.rd) chk("req_wdata", cif.core_wdata, e.wdata);
                end
                if (cif.core_wr != 4'h0) begin
                    old = rd_mem(cif.core_addr);
                    for (int b = 0; b < 4; b++)
                        if (cif.core_wr[b]) old[b*8 +: 8] = cif.core_wdata[b*8 +: 8];
                    mem[cif.core_addr] = old;
                end
                pend = 1'b1;
                pend_rd = cif.core_rd;
                pend_addr = cif.core_addr;
                resp_wait = 1;
                have_prev = 1'b0;
                chk_clear = 1'b1;
                stall_left = cur_stall;
            end else begin
                cif.core_rdy = 1'b0;
                have_prev = 1'b0;
                stall_left = cur_stall;
            end
        end
    end

    task automatic start_line(input vec_t v);
        logic [AW-1:0] base;
        int start;
        int i;
        req_t r;
        base = v.addr & ~AW'(15);
        start = 0;
`ifdef SDRAM_LINE_CWF_EN
        if (!v.we) start = int'(v.addr[3:2]);
`endif
        for (int k = 0; k < LW; k++) begin
            i = (start + k) % LW;
            if (v.we && v.wstrb[i*4 +: 4] == 4'h0) continue;
            r.rd = !v.we;
            r.wr = v.we ? v.wstrb[i*4 +: 4] : 4'h0;
            r.addr = base + AW'(i * 4);
            r.wdata = v.wdata[i*32 +: 32];
            exp_q.push_back(r);
        end
        cur_stall = v.stall;
        @(negedge clk);
        lif.line_req = 1'b1;
        lif.line_we = v.we;
        lif.line_addr = v.addr;
        lif.line_wdata = v.wdata;
        lif.line_wstrb = v.wstrb;
        @(posedge clk);
        #1;
        lif.line_req = 1'b0;
        chk("busy_after_capture", lif.line_busy, 1);
    endtask

    task automatic run_line(input vec_t v, input int n);
        int cyc;
        int p0;
        int d0;
        p0 = pops;
        d0 = done_cnt;
        start_line(v);
        cyc = 1;
        while (lif.line_done !== 1'b1 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk($sformatf("v%0d_done_seen", n), lif.line_done, 1);
        if (v.exp_cyc > 0) chk($sformatf("v%0d_latency", n), cyc, v.exp_cyc);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_idle", n), {lif.line_busy, lif.line_done}, 0);
        chk($sformatf("v%0d_done_once", n), done_cnt - d0, 1);
        chk($sformatf("v%0d_nreq", n), pops - p0, v.exp_reqs);
        chk($sformatf("v%0d_sb_empty", n), exp_q.size(), 0);
        chk($sformatf("v%0d_rdata", n), lif.line_rdata, v.exp_rdata);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_line"}, {lif.line_busy, lif.line_done, lif.line_rdata}, 0);
        chk({nm, "_core"}, {cif.core_rd, cif.core_wr, cif.core_addr,
                            cif.core_wdata}, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d0;
        int p0;
        int cyc;
        vec_t cw;
        vecs[0] = '{1'b0, 25'h000100, 128'h0, 16'h0, 0, 4, 17,
                    128'h44444444_33333333_22222222_11111111};
        vecs[1] = '{1'b1, 25'h000200,
                    128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 16'h0F0F,
                    0, 2, 11,
                    128'h44444444_33333333_22222222_11111111};
        vecs[2] = '{1'b0, 25'h000204, 128'h0, 16'h0, 0, 4, 17,
                    128'hD000020C_CCCCCCCC_D0000204_AAAAAAAA};
        vecs[3] = '{1'b1, 25'h000300,
                    128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 16'h0000,
                    0, 0, 5,
                    128'hD000020C_CCCCCCCC_D0000204_AAAAAAAA};
        vecs[4] = '{1'b1, 25'h1FFFFFF,
                    128'h0D0E0F10_090A0B0C_05060708_01020304, 16'h3C81,
                    0, 4, 17,
                    128'hD000020C_CCCCCCCC_D0000204_AAAAAAAA};
        vecs[5] = '{1'b0, 25'h1FFFFF0, 128'h0, 16'h0, 0, 4, 17,
                    128'hD1FF0F10_090AFFF8_05FFFFF4_D1FFFF04};
        vecs[6] = '{1'b1, 25'h000400,
                    128'h77777777_66666666_600DF00D_55555555, 16'h00F0,
                    20, 1, 28,
                    128'hD1FF0F10_090AFFF8_05FFFFF4_D1FFFF04};
        vecs[7] = '{1'b0, 25'h000400, 128'h0, 16'h0, 0, 4, 17,
                    128'hD000040C_D0000408_600DF00D_D0000400};

        mem[25'h100] = 32'h11111111;
        mem[25'h104] = 32'h22222222;
        mem[25'h108] = 32'h33333333;
        mem[25'h10C] = 32'h44444444;

        lif.line_req = 1'b0;
        lif.line_we = 1'b0;
        lif.line_addr = '0;
        lif.line_wdata = '0;
        lif.line_wstrb = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 8; n++) run_line(vecs[n], n);

        // Stray valids while idle must be ignored.
        d0 = done_cnt;
        spur = 1'b1;
        @(negedge clk);
        @(negedge clk);
        spur = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("spur_rdata", lif.line_rdata, vecs[7].exp_rdata);
        chk("spur_no_done", done_cnt - d0, 0);
        chk("spur_idle", lif.line_busy, 0);

        // line_req held high through line_done: next capture one cycle later.
        d0 = done_cnt;
        @(negedge clk);
        lif.line_req = 1'b1;
        lif.line_we = 1'b1;
        lif.line_addr = 25'h000500;
        lif.line_wstrb = 16'h0;
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_done1", lif.line_done, 1);
        @(posedge clk);
        #1;
        chk("b2b_gap", {lif.line_busy, lif.line_done}, 0);
        @(posedge clk);
        #1;
        chk("b2b_recapture", lif.line_busy, 1);
        lif.line_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_done2", lif.line_done, 1);
        @(posedge clk);
        #1;
        chk("b2b_done_count", done_cnt - d0, 2);

        // Reset while waiting on word 2 of a read line.
        p0 = pops;
        start_line(vecs[0]);
        cyc = 0;
        while (pops - p0 < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_reached_word2", pops - p0, 3);
        @(negedge clk);
        rst = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_no_done", done_cnt - d0, 0);
        chk_zero("mid_after");
        run_line(vecs[0], 8);

`ifdef SDRAM_LINE_CWF_EN
        cw = vecs[0];
        cw.addr = 25'h000108;
        run_line(cw, 9);
`else
        cw = vecs[0];
`endif
        chk("final_rdata", lif.line_rdata, cw.exp_rdata);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
